lift_scheduler: RTL

Request scheduler and sequencer for the 3-floor lift position counter (one-hot floor state GROUND=001, ONE=010, TWO=100; one step per `start`-qualified clock). It latches call buttons and chooses direction with SCAN (keep direction while calls remain ahead). It drives the counter's `req_floor` and `start` inputs one floor at a time, paced by a travel timer, and holds the door open at served floors. It sits between the button/panel logic and the position counter, whose `count_out` feeds back as `cur_floor`.

---
 rtl/lift_scheduler.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/lift_scheduler.sv
// -----------------------------------------------------------------------------
// lift_scheduler
//
// Request scheduler and sequencer for a three-floor lift. The block latches
// call buttons, picks a travel direction with SCAN (keep going while calls
// remain ahead), and steps the external position counter one floor at a time.
// A shared timer paces each floor step and holds the door open at served floors.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   rst_n      : synchronous active-low reset
//   call_btn   : per-floor call request (bit0 = GROUND, bit2 = TWO)
//   cur_floor  : one-hot current floor from the position counter
//   req_floor  : one-hot adjacent floor to step toward (000 outside MOVE)
//   start      : one-cycle step enable to the position counter
//   door_open  : high while the door is held open
//   dir        : travel direction, 1 = up, 0 = down
//   pending    : latched outstanding calls
//   fault      : high while cur_floor is not one-hot
// -----------------------------------------------------------------------------
module lift_scheduler #(
    parameter int DOOR_CYCLES   = 4,
    parameter int TRAVEL_CYCLES = 3,
    parameter int TW            = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] call_btn,
    input  logic [2:0] cur_floor,
    output logic [2:0] req_floor,
    output logic       start,
    output logic       door_open,
    output logic       dir,
    output logic [2:0] pending,
    output logic       fault
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MOVE  = 2'd1,
        S_CHECK = 2'd2,
        S_DOOR  = 2'd3
    } state_t;

    localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);
    localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ZERO  = {TW{1'b0}};

    // Floors strictly above the given one-hot floor.
    function automatic logic [2:0] above_mask(input logic [2:0] floor_v);
        logic [2:0] m;
        case (floor_v)
            3'b001:  m = 3'b110;
            3'b010:  m = 3'b100;
            3'b100:  m = 3'b000;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

    // Floors strictly below the given one-hot floor.
    function automatic logic [2:0] below_mask(input logic [2:0] floor_v);
        logic [2:0] m;
        case (floor_v)
            3'b001:  m = 3'b000;
            3'b010:  m = 3'b001;
            3'b100:  m = 3'b011;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

    // Adjacent floor in the given direction; only used when a call lies that way.
    function automatic logic [2:0] step_floor(input logic [2:0] floor_v, input logic up_v);
        logic [2:0] f;
        if (up_v) begin
            f = {floor_v[1:0], 1'b0};
        end else begin
            f = {1'b0, floor_v[2:1]};
        end
        return f;
    endfunction

    state_t        state_r;
    logic [TW-1:0] timer_r;
    logic          dir_r;
    logic [2:0]    pending_r;
    logic [2:0]    req_r;

    state_t        nxt_state_s;
    logic [TW-1:0] nxt_timer_s;
    logic          nxt_dir_s;
    logic [2:0]    nxt_req_s;
    logic [2:0]    clr_s;
    logic [2:0]    latch_s;
    logic          onehot_s;
    logic          here_s;
    logic [2:0]    ahead_s;
    logic [2:0]    behind_s;
    logic          door_hit_s;

    assign onehot_s = (cur_floor == 3'b001) || (cur_floor == 3'b010) || (cur_floor == 3'b100);
    assign here_s   = |(pending_r & cur_floor);
    assign ahead_s  = pending_r & (dir_r ? above_mask(cur_floor) : below_mask(cur_floor));
    assign behind_s = pending_r & (dir_r ? below_mask(cur_floor) : above_mask(cur_floor));

    // A call for the floor whose door is open extends the dwell instead of latching.
    assign door_hit_s = (state_r == S_DOOR) && (|(call_btn & cur_floor));
    assign latch_s    = call_btn & ~((state_r == S_DOOR) ? cur_floor : 3'b000);

    // Next-state, timer, direction and step target decode.
    always_comb begin
        nxt_state_s = state_r;
        nxt_timer_s = timer_r;
        nxt_dir_s   = dir_r;
        nxt_req_s   = req_r;
        clr_s       = 3'b000;
        case (state_r)
            S_IDLE, S_CHECK: begin
                if (!onehot_s) begin
                    nxt_state_s = S_IDLE;
                end else if (here_s) begin
                    nxt_state_s = S_DOOR;
                    nxt_timer_s = DOOR_LOAD;
                    clr_s       = cur_floor;
                end else if (ahead_s != 3'b000) begin
                    nxt_state_s = S_MOVE;
                    nxt_timer_s = TRAVEL_LOAD;
                    nxt_req_s   = step_floor(cur_floor, dir_r);
                end else if (behind_s != 3'b000) begin
                    nxt_state_s = S_MOVE;
                    nxt_timer_s = TRAVEL_LOAD;
                    nxt_dir_s   = ~dir_r;
                    nxt_req_s   = step_floor(cur_floor, ~dir_r);
                end else begin
                    nxt_state_s = S_IDLE;
                end
            end
            S_MOVE: begin
                if (!onehot_s) begin
                    nxt_state_s = S_IDLE;
                end else if (timer_r == TIMER_ZERO) begin
                    nxt_state_s = S_CHECK;
                end else begin
                    nxt_timer_s = timer_r - {{(TW-1){1'b0}}, 1'b1};
                end
            end
            S_DOOR: begin
                if (door_hit_s) begin
                    nxt_timer_s = DOOR_LOAD;
                end else if (timer_r == TIMER_ZERO) begin
                    nxt_state_s = S_IDLE;
                end else begin
                    nxt_timer_s = timer_r - {{(TW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                nxt_state_s = S_IDLE;
            end
        endcase
    end

    // State, timer, direction, step target and pending-call registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            timer_r   <= TIMER_ZERO;
            dir_r     <= 1'b1;
            pending_r <= 3'b000;
            req_r     <= 3'b000;
        end else begin
            state_r   <= nxt_state_s;
            timer_r   <= nxt_timer_s;
            dir_r     <= nxt_dir_s;
            pending_r <= (pending_r | latch_s) & ~clr_s;
            req_r     <= nxt_req_s;
        end
    end

    // Outputs come straight from registered state; start is withheld on a bad floor code.
    assign req_floor = (state_r == S_MOVE) ? req_r : 3'b000;
    assign start     = (state_r == S_MOVE) && (timer_r == TIMER_ZERO) && onehot_s;
    assign door_open = (state_r == S_DOOR);
    assign dir       = dir_r;
    assign pending   = pending_r;
    assign fault     = ~onehot_s;

endmodule
